// File: rtl/tff_updown_counter_if.sv
// Count-control and count-status bundle for tff_updown_counter.
// master drives controls, slave (the counter) drives status.
interface tff_updown_counter_if #(
   parameter int W = 4
);
   logic         en;
   logic         up;
   logic         load;
   logic [W-1:0] din;
   logic [W-1:0] q;
   logic [W-1:0] t_vec;
   logic         tc;

   modport master (
      output en, up, load, din,
      input  q, t_vec, tc
   );

   modport slave (
      input  en, up, load, din,
      output q, t_vec, tc
   );
endinterface

// File: rtl/tff_updown_counter.sv
// Modulo-MOD up/down counter that also publishes the T flip-flop
// toggle mask for the next edge and a one-cycle terminal-count pulse.
module tff_updown_counter #(
   parameter int W   = 4,
   parameter int MOD = 10
) (
   input  logic               CLK,
   input  logic               rst,
   tff_updown_counter_if.slave bus
);

   if (MOD < 2 || longint'(MOD) > (longint'(1) << W)) begin : g_bad_mod
      $error("tff_updown_counter: MOD must lie in 2..2**W");
   end

   localparam logic [W-1:0] MAX = W'(MOD - 1);

   logic [W-1:0] q_r;
   logic         tc_r;
   logic [W-1:0] next_q;
   logic         wrap;

   // Next count and wrap flag: load (clamped) beats en beats hold.
   always_comb begin
      next_q = q_r;
      wrap   = 1'b0;
      if (bus.load) begin
         next_q = (bus.din > MAX) ? MAX : bus.din;
      end else if (bus.en) begin
         if (bus.up) begin
            if (q_r == MAX) begin
               next_q = '0;
               wrap   = 1'b1;
            end else begin
               next_q = q_r + W'(1);
            end
         end else begin
            if (q_r == '0) begin
               next_q = MAX;
               wrap   = 1'b1;
            end else begin
               next_q = q_r - W'(1);
            end
         end
      end
   end

   // Count register and terminal-count pulse, cleared asynchronously.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         q_r  <= '0;
         tc_r <= 1'b0;
      end else begin
         q_r  <= next_q;
         tc_r <= wrap;
      end
   end

   // The toggle mask is forced quiet while the bank is held in reset.
   assign bus.t_vec = rst ? (q_r ^ next_q) : '0;
   assign bus.q     = q_r;
   assign bus.tc    = tc_r;

   // A count outside 0..MOD-1 would mean the bank has lost sync.
   q_in_range: assert property (
      @(posedge CLK) disable iff (!rst) q_r <= MAX
   );

endmodule

// File: tb/tb_tff_updown_counter.sv
// Scoreboard bench for tff_updown_counter: a MOD=10 and a MOD=2 instance.
// Expected q/tc are queued at each edge and compared just after it.
module tb_tff_updown_counter;

   typedef struct {
      int q;
      int tc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   mq_a   = 0;
   int   mq_b   = 0;

   tff_updown_counter_if #(.W(4)) a ();
   tff_updown_counter_if #(.W(1)) b ();

   tff_updown_counter #(.W(4), .MOD(10)) dut_a (
      .CLK (clk),
      .rst (rst),
      .bus (a)
   );

   tff_updown_counter #(.W(1), .MOD(2)) dut_b (
      .CLK (clk),
      .rst (rst),
      .bus (b)
   );

   always #5 clk = ~clk;

   function automatic exp_t nxt(int q, int m, bit ld, bit en, bit up,
                                int din);
      exp_t e;
      e.q  = q;
      e.tc = 0;
      if (ld) begin
         e.q = (din >= m) ? m - 1 : din;
      end else if (en) begin
         if (up) begin
            if (q == m - 1) begin
               e.q  = 0;
               e.tc = 1;
            end else begin
               e.q = q + 1;
            end
         end else begin
            if (q == 0) begin
               e.q  = m - 1;
               e.tc = 1;
            end else begin
               e.q = q - 1;
            end
         end
      end
      return e;
   endfunction

   // Queue the model's prediction for dut_a, then take the edge.
   task automatic edge_a();
      exp_t e;
      e = nxt(mq_a, 10, a.load, a.en, a.up, int'(a.din));
      if (!rst) e = '{0, 0};
      sb.push_back(e);
      mq_a = e.q;
      @(posedge clk);
      #1;
   endtask

   task automatic edge_b();
      exp_t e;
      e = nxt(mq_b, 2, b.load, b.en, b.up, int'(b.din));
      if (!rst) e = '{0, 0};
      sb.push_back(e);
      mq_b = e.q;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_up_wrap();
      exp_t e;
      int   tcs;
      a.en = 1'b1; a.up = 1'b1; a.load = 1'b0; a.din = '0;
      b.en = 1'b0; b.up = 1'b1; b.load = 1'b0; b.din = '0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if (a.q !== 4'd0 || a.tc !== 1'b0 || b.q !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: q=%0d tc=%0d bq=%0d want 0 0 0",
                  a.q, a.tc, b.q);
      end
      checks++;
      if (a.t_vec !== 4'd0) begin
         errors++;
         $display("FAIL rst_tvec: t_vec=%b want 0000", a.t_vec);
      end
      @(negedge clk);
      rst = 1'b1;
      mq_a = 0; mq_b = 0;
      tcs = 0;
      for (int i = 0; i < 12; i++) begin
         if (mq_a == 9) begin
            checks++;
            if (a.t_vec !== 4'b1001) begin
               errors++;
               $display("FAIL tvec_at9: t_vec=%b want 1001", a.t_vec);
            end
         end
         edge_a();
         e = sb.pop_front();
         checks++;
         if (a.q !== 4'(e.q) || a.tc !== 1'(e.tc)) begin
            errors++;
            $display("FAIL up_count[%0d]: q=%0d tc=%0d want q=%0d tc=%0d",
                     i, a.q, a.tc, e.q, e.tc);
         end
         if (a.tc === 1'b1) tcs++;
      end
      checks++;
      if (a.q !== 4'd2 || tcs != 1) begin
         errors++;
         $display("FAIL up_final: q=%0d tc_count=%0d want q=2 tc_count=1",
                  a.q, tcs);
      end
   endtask

   task automatic test_down_wrap();
      exp_t e;
      a.load = 1'b1; a.din = 4'd0; a.en = 1'b0;
      edge_a();
      e = sb.pop_front();
      checks++;
      if (a.q !== 4'(e.q) || a.tc !== 1'b0) begin
         errors++;
         $display("FAIL load0: q=%0d tc=%0d want 0 0", a.q, a.tc);
      end
      a.load = 1'b0; a.en = 1'b1; a.up = 1'b0;
      #1;
      checks++;
      if (a.t_vec !== 4'b1001) begin
         errors++;
         $display("FAIL tvec_at0: t_vec=%b want 1001", a.t_vec);
      end
      for (int i = 0; i < 3; i++) begin
         edge_a();
         e = sb.pop_front();
         checks++;
         if (a.q !== 4'(e.q) || a.tc !== 1'(e.tc)
             || a.q !== 4'(9 - i) || a.tc !== (i == 0)) begin
            errors++;
            $display("FAIL down[%0d]: q=%0d tc=%0d want q=%0d tc=%0d",
                     i, a.q, a.tc, e.q, e.tc);
         end
      end
   endtask

   task automatic test_load_clamp();
      exp_t e;
      a.load = 1'b1; a.en = 1'b1; a.up = 1'b1; a.din = 4'd6;
      edge_a();
      e = sb.pop_front();
      checks++;
      if (a.q !== 4'd6 || a.tc !== 1'b0 || e.q != 6) begin
         errors++;
         $display("FAIL load6: q=%0d tc=%0d want 6 0", a.q, a.tc);
      end
      a.en = 1'b0; a.din = 4'd13;
      #1;
      checks++;
      if (a.t_vec !== 4'b1111) begin
         errors++;
         $display("FAIL tvec_clamp: t_vec=%b want 1111", a.t_vec);
      end
      edge_a();
      e = sb.pop_front();
      checks++;
      if (a.q !== 4'd9 || a.tc !== 1'b0 || e.q != 9) begin
         errors++;
         $display("FAIL clamp13: q=%0d tc=%0d want 9 0", a.q, a.tc);
      end
      a.din = 4'd9;
      #1;
      checks++;
      if (a.t_vec !== 4'd0) begin
         errors++;
         $display("FAIL tvec_same: t_vec=%b want 0000", a.t_vec);
      end
      a.en = 1'b1;
      edge_a();
      e = sb.pop_front();
      checks++;
      if (a.q !== 4'(e.q) || a.tc !== 1'b0) begin
         errors++;
         $display("FAIL load_en_wrap: q=%0d tc=%0d want %0d 0",
                  a.q, a.tc, e.q);
      end
   endtask

   task automatic test_hold();
      exp_t e;
      a.load = 1'b1; a.din = 4'd4; a.en = 1'b0;
      edge_a();
      void'(sb.pop_front());
      a.load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a.up = 1'(i);
         #1;
         checks++;
         if (a.t_vec !== 4'd0) begin
            errors++;
            $display("FAIL hold_tvec[%0d]: t_vec=%b want 0000", i, a.t_vec);
         end
         edge_a();
         e = sb.pop_front();
         checks++;
         if (a.q !== 4'd4 || a.tc !== 1'b0 || e.q != 4) begin
            errors++;
            $display("FAIL hold[%0d]: q=%0d tc=%0d want 4 0", i, a.q, a.tc);
         end
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      a.load = 1'b1; a.din = 4'd0;
      edge_a();
      void'(sb.pop_front());
      a.load = 1'b0; a.en = 1'b1; a.up = 1'b0;
      edge_a();
      void'(sb.pop_front());
      checks++;
      if (a.q !== 4'd9 || a.tc !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: q=%0d tc=%0d want 9 1", a.q, a.tc);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (a.q !== 4'd0 || a.tc !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst: q=%0d tc=%0d want 0 0", a.q, a.tc);
      end
      a.up = 1'b1;
      for (int i = 0; i < 3; i++) begin
         edge_a();
         e = sb.pop_front();
         checks++;
         if (a.q !== 4'd0 || a.tc !== 1'b0 || a.t_vec !== 4'd0) begin
            errors++;
            $display("FAIL rst_hold[%0d]: q=%0d tc=%0d tv=%b want 0 0 0",
                     i, a.q, a.tc, a.t_vec);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      mq_a = 0; mq_b = 0;
      for (int i = 0; i < 2; i++) begin
         edge_a();
         e = sb.pop_front();
         checks++;
         if (a.q !== 4'(e.q) || a.q !== 4'(i + 1) || a.tc !== 1'b0) begin
            errors++;
            $display("FAIL resume[%0d]: q=%0d tc=%0d want %0d 0",
                     i, a.q, a.tc, i + 1);
         end
      end
      a.en = 1'b0;
   endtask

   task automatic test_min_mod();
      exp_t e;
      b.en = 1'b1; b.up = 1'b1; b.load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (b.t_vec !== 1'b1) begin
            errors++;
            $display("FAIL mod2_tvec[%0d]: t_vec=%b want 1", i, b.t_vec);
         end
         edge_b();
         e = sb.pop_front();
         checks++;
         if (b.q !== 1'(e.q) || b.tc !== 1'(e.tc)
             || b.q !== 1'(~i) || b.tc !== 1'(i)) begin
            errors++;
            $display("FAIL mod2[%0d]: q=%0d tc=%0d want q=%0d tc=%0d",
                     i, b.q, b.tc, e.q, e.tc);
         end
      end
   endtask

   initial begin
      test_reset_up_wrap();
      test_down_wrap();
      test_load_clamp();
      test_hold();
      test_mid_reset();
      test_min_mod();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
